// File: rtl/prog_loader_mem_pkg.sv
// Shared definitions for the program loader / instruction memory block:
// default widths, the loader state encoding and a width helper.
package prog_loader_mem_pkg;

   localparam int D_WIDTH_DEF  = 32;
   localparam int SA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF    = 16;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } ld_state_e;

   // Index width that stays legal (>= 1 bit) for a count of one.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_loader_mem_if.sv
// Byte-stream load channel plus the core's instruction fetch bus.
interface prog_loader_mem_if #(
   parameter int D_WIDTH  = 32,
   parameter int SA_WIDTH = 8
);
   logic [7:0]          Ld_Data;
   logic                Ld_Valid;
   logic                Ld_Last;
   logic                Ld_Ready;
   logic [SA_WIDTH-1:0] Addr;
   logic                En;
   logic                RW;
   logic [D_WIDTH-1:0]  Data;

   modport master (
      output Ld_Data, Ld_Valid, Ld_Last, Addr, En, RW,
      input  Ld_Ready, Data
   );

   modport slave (
      input  Ld_Data, Ld_Valid, Ld_Last, Addr, En, RW,
      output Ld_Ready, Data
   );
endinterface

// File: rtl/prog_loader_mem_prog_ram.sv
// Single-port program RAM: synchronous write, registered read.
// Loading and fetching never overlap, so one address port serves both.
module prog_loader_mem_prog_ram #(
   parameter int D_WIDTH = 32,
   parameter int DEPTH   = 16,
   parameter int AW      = 4
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [AW-1:0]      addr_i,
   input  logic [D_WIDTH-1:0] wdata_i,
   output logic [D_WIDTH-1:0] rdata_o
);
   logic [D_WIDTH-1:0] mem_q [DEPTH];
   logic [D_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_loader_mem.sv
// Instruction memory with big-endian byte-stream loader; holds the core in
// reset while loading, then serves fetches with one-cycle read latency.
module prog_loader_mem
   import prog_loader_mem_pkg::*;
#(
   parameter int D_WIDTH  = D_WIDTH_DEF,
   parameter int SA_WIDTH = SA_WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   prog_loader_mem_if.slave  bus,
   output logic              Core_Rst,
   output logic              Loaded,
   output logic [SA_WIDTH:0] Word_Count,
   output logic              Err
);
   localparam int BPW = D_WIDTH / 8;
   localparam int IW  = idx_width(BPW);
   localparam int AW  = idx_width(DEPTH);
   localparam logic [SA_WIDTH:0] DEPTH_PTR = (SA_WIDTH+1)'(DEPTH);
   localparam logic [IW-1:0]     LAST_IDX  = IW'(BPW - 1);

   ld_state_e          state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [SA_WIDTH:0]  ptr_q, ptr_d;
   logic [D_WIDTH-1:0] wbuf_q, wbuf_d;
   logic               err_q, err_d;
   logic               hit_q, hit_d;

   logic               accept;
   logic               full;
   logic               word_done;
   logic [D_WIDTH-1:0] byte_hi;
   logic [D_WIDTH-1:0] merged;

   logic               ram_we;
   logic               ram_re;
   logic [AW-1:0]      ram_addr;
   logic [D_WIDTH-1:0] ram_rdata;

   assign bus.Ld_Ready = (state_q == ST_LOAD) && Rst;
   assign accept       = bus.Ld_Valid && bus.Ld_Ready;
   assign full         = (ptr_q == DEPTH_PTR);
   assign word_done    = (idx_q == LAST_IDX) || bus.Ld_Last;

   // Incoming byte lands at the big-endian lane selected by idx_q; lanes
   // after it are still zero, which gives the padding for a short last word.
   assign byte_hi = D_WIDTH'(bus.Ld_Data) << (D_WIDTH - 8);
   assign merged  = wbuf_q | (byte_hi >> {idx_q, 3'b000});

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         ptr_q   <= '0;
         wbuf_q  <= '0;
         err_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         wbuf_q  <= wbuf_d;
         err_q   <= err_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      wbuf_d   = wbuf_q;
      err_d    = err_q;
      hit_d    = hit_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = ptr_q[AW-1:0];

      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (full) begin
                  err_d = 1'b1;
               end else if (word_done) begin
                  ram_we = 1'b1;
                  ptr_d  = ptr_q + 1'b1;
                  idx_d  = '0;
                  wbuf_d = '0;
               end else begin
                  wbuf_d = merged;
                  idx_d  = idx_q + 1'b1;
               end
               if (bus.Ld_Last) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.En) begin
               if (bus.RW) begin
                  err_d = 1'b1;
               end else begin
                  // Out-of-range reads still touch the RAM; hit_q masks them.
                  ram_re   = 1'b1;
                  ram_addr = bus.Addr[AW-1:0];
                  hit_d    = ({1'b0, bus.Addr} < ptr_q);
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   prog_loader_mem_prog_ram #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_prog_ram (
      .clk     (Clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (merged),
      .rdata_o (ram_rdata)
   );

   assign bus.Data   = hit_q ? ram_rdata : '0;
   assign Core_Rst   = (state_q != ST_RUN);
   assign Loaded     = (state_q == ST_RUN);
   assign Word_Count = ptr_q;
   assign Err        = err_q;
endmodule

// File: doc/prog_loader_mem.md
# prog_loader_mem

Instruction memory with a byte-stream program loader, sitting directly upstream of the GPP core. It accepts a program as a big-endian byte stream, packs the bytes into `D_WIDTH`-bit words, and holds the core in reset while loading. When loading ends it releases the core and serves the core's instruction fetches over the `Addr`/`En`/`RW`/`Data` bus with one-cycle registered read latency.

## Interface
Parameters:
- `D_WIDTH`, 32: instruction word width. Must be a multiple of 8.
- `SA_WIDTH`, from `define.h`: fetch address width.
- `DEPTH`, `SL_WIDTH`: number of program words stored. `DEPTH <= 2**SA_WIDTH`.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  reset, synchronous, active-low.
- `Ld_Data`  in  8  program byte.
- `Ld_Valid`  in  1  `Ld_Data` valid.
- `Ld_Last`  in  1  qualifies the final byte of the program; meaningful only with `Ld_Valid`.
- `Ld_Ready`  out  1  loader can accept a byte.
- `Addr`  in  `SA_WIDTH`  fetch word address from the core.
- `En`  in  1  fetch request.
- `RW`  in  1  0 = read, 1 = write. Writes are unsupported.
- `Data`  out  `D_WIDTH`  fetched instruction, registered.
- `Core_Rst`  out  1  active-high reset to the core.
- `Loaded`  out  1  high in RUN.
- `Word_Count`  out  `SA_WIDTH+1`  number of words written.
- `Err`  out  1  sticky error flag.

## Operation
- States:
  - LOAD: entered from reset. Leaves for RELEASE when a byte with `Ld_Last` is accepted.
  - RELEASE: lasts exactly 1 cycle, then goes to RUN.
  - RUN: holds until reset.
- Byte handshake: a byte is accepted on a rising edge where `Ld_Valid && Ld_Ready`. `Ld_Ready` is 1 only in LOAD and only while `Rst` is high.
- Packing:
  - A 2-bit byte index and a word pointer start at 0.
  - The first byte of each word goes to bits `[D_WIDTH-1 -: 8]`, big-endian.
  - When the 4th byte is accepted, the word is written to `mem[ptr]`, then `ptr` and `Word_Count` increment.
- `Ld_Last` on byte 1–3 of a word: the remaining bytes are zero-padded and the word is written on that same edge.
- Overflow: a byte accepted when `ptr == DEPTH` is dropped and `Err` is set to 1. LOAD continues, so `Ld_Last` is still honoured.
- `Core_Rst` is 1 in LOAD and RELEASE, and 0 in RUN.
- Fetch:
  - Applies only in RUN, on an edge with `En=1`, `RW=0`: `Data <= (Addr < Word_Count) ? mem[Addr] : 0`.
  - Unloaded and out-of-range addresses return 0, which the core executes as a NOP (`sll $0,$0,0`).
  - `Data` holds its value until the next accepted read.
- Invalid fetch requests:
  - `En=1`, `RW=1` in RUN: the request is ignored, `Data` is unchanged, and `Err` is set to 1.
  - `En` in LOAD or RELEASE: ignored, with no error.
- Reset (`Rst=0` at an edge), including mid-load or mid-run:
  - state ← LOAD, byte index and `ptr` ← 0.
  - Outputs return to their reset values.
  - Memory contents are not cleared; they are masked because `Word_Count = 0`.

## Timing
- Reset values while `Rst` is sampled low:
  - `Ld_Ready`=0, `Core_Rst`=1, `Loaded`=0, `Data`=0, `Word_Count`=0, `Err`=0.
- Load throughput: 1 byte per cycle.
- Word write: occurs on the edge that accepts the byte completing the word. `Word_Count` is visible on the next cycle.
- Core release: the edge accepting `Ld_Last` enters RELEASE. The next edge enters RUN, and `Core_Rst` falls in that cycle. The core therefore sees at least one more rising edge with `Rst` high, so it starts in `S_initial`.
- Read latency: `En` sampled at edge N gives `Data` valid after edge N. It stays stable through the core's fetch2 and decode states.
- Simultaneous events:
  - Overflow and `Ld_Last` on the same byte: the byte is dropped, `Err`=1, and the state still goes to RELEASE.
  - Reset beats everything.

## Structure
- `D_WIDTH`, `SA_WIDTH` and `SL_WIDTH` stay in `define.h`.
- State encodings are local parameters.
- One sub-module, `prog_ram`: a single-port synchronous-write RAM with registered read, `DEPTH × D_WIDTH`. Write and read never coincide, because LOAD and RUN are disjoint.
- The FSM, packer, counters and read mask live in `prog_loader_mem`.

## Test plan
- Basic load and fetch, `DEPTH`=16:
  - Stimulus: bytes 20 01 00 05 00 01 10 40, `Ld_Last` on the 8th.
  - Expect `Word_Count`=2 and `Core_Rst` falling 2 cycles after the last accept.
  - Fetch Addr 0 → `Data`=0x20010005 one cycle later; Addr 1 → 0x00011040; Addr 5 → 0.
- Partial word: 6 bytes 20 01 00 05 AA BB, `Ld_Last` on the 6th → `mem[1]`=0xAABB0000, `Word_Count`=2, `Err`=0.
- Backpressure and gaps:
  - Toggle `Ld_Valid` randomly; hold `Ld_Valid` in RUN.
  - Expect identical memory contents and `Ld_Ready`=0 after RELEASE.
- Overflow, `DEPTH`=4: 20 bytes, last flagged → `Word_Count`=4, `Err`=1, words 0–3 equal the first 16 bytes, and RUN is still entered.
- Illegal access:
  - `En=1`, `RW=1` in RUN → `Err`=1, `Data` unchanged.
  - `En` during LOAD → no error, `Data`=0.
- Reset mid-run:
  - Assert `Rst`=0 for 1 cycle while fetching → `Core_Rst`=1, `Word_Count`=0, `Data`=0, `Ld_Ready`=1 next cycle.
  - Reload a 1-word program; fetch of Addr 1 → 0.
